// File: rtl/or1200_wb_arbiter.sv
// Two-master (IWB=0, DWB=1) to one-slave Wishbone arbiter with a hung-slave watchdog.
// Latency: grant is registered (1 cycle after request); request/response paths are combinational once granted.
// Backpressure: the owner keeps the bus for its whole cyc; the other master waits; stalled strobes are aborted after TIMEOUT cycles.
//
// Ports: clk_i/rst_i (sync active-high reset); m_* = packed per-master bus (master k in slice k);
// swb_* = shared slave bus; gnt_o = one-hot owner (00 idle); timeout_o = one-cycle watchdog abort pulse.
module or1200_wb_arbiter #(
    parameter int AW         = 32,
    parameter int DW         = 32,
    parameter int PRIORITY_D = 0,
    parameter int TIMEOUT    = 16,
    parameter int TW         = 5
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [1:0]        m_cyc_i,
    input  logic [1:0]        m_stb_i,
    input  logic [1:0]        m_we_i,
    input  logic [2*DW/8-1:0] m_sel_i,
    input  logic [2*AW-1:0]   m_adr_i,
    input  logic [2*DW-1:0]   m_dat_i,
    output logic [DW-1:0]     m_dat_o,
    output logic [1:0]        m_ack_o,
    output logic [1:0]        m_err_o,
    output logic              swb_cyc_o,
    output logic              swb_stb_o,
    output logic              swb_we_o,
    output logic [DW/8-1:0]   swb_sel_o,
    output logic [AW-1:0]     swb_adr_o,
    output logic [DW-1:0]     swb_dat_o,
    input  logic [DW-1:0]     swb_dat_i,
    input  logic              swb_ack_i,
    input  logic              swb_err_i,
    output logic [1:0]        gnt_o,
    output logic              timeout_o
);
    localparam int SW = DW / 8;

    typedef enum logic [1:0] {IDLE, OWN_I, OWN_D} state_t;

    state_t        state, state_nxt;
    logic          last_d, last_d_nxt;     // 1 = DWB owned the bus last
    logic [TW-1:0] cnt, cnt_nxt;           // stalled-strobe cycles seen so far
    logic [1:0]    gnt_nxt;

    logic [1:0]    req;
    logic          g;                      // granted master index
    logic          cyc_g, stb_g, stalled, abort, win_d;

    assign req = m_cyc_i & m_stb_i;
    assign g   = (state == OWN_D);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state  <= IDLE;
            last_d <= 1'b0;
            cnt    <= '0;
            gnt_o  <= 2'b00;
        end else begin
            state  <= state_nxt;
            last_d <= last_d_nxt;
            cnt    <= cnt_nxt;
            gnt_o  <= gnt_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        last_d_nxt = last_d;
        cnt_nxt    = cnt;
        gnt_nxt    = gnt_o;
        m_dat_o    = swb_dat_i;
        m_ack_o    = 2'b00;
        m_err_o    = 2'b00;
        swb_cyc_o  = 1'b0;
        swb_stb_o  = 1'b0;
        swb_we_o   = 1'b0;
        swb_sel_o  = '0;
        swb_adr_o  = '0;
        swb_dat_o  = '0;
        timeout_o  = 1'b0;
        cyc_g      = 1'b0;
        stb_g      = 1'b0;
        stalled    = 1'b0;
        abort      = 1'b0;
        win_d      = 1'b0;

        case (state)
            IDLE: begin
                cnt_nxt = '0;
                // On a tie, round-robin favours whoever did not own the bus last.
                if (req == 2'b11)
                    win_d = (PRIORITY_D != 0) ? 1'b1 : ~last_d;
                else
                    win_d = req[1];
                if (req != 2'b00) begin
                    state_nxt = win_d ? OWN_D : OWN_I;
                    gnt_nxt   = win_d ? 2'b10 : 2'b01;
                end
            end
            OWN_I, OWN_D: begin
                cyc_g   = m_cyc_i[g];
                stb_g   = cyc_g & m_stb_i[g];
                stalled = stb_g & ~swb_ack_i & ~swb_err_i;
                // Counter holds TIMEOUT only after TIMEOUT stalled cycles; a slave
                // response in this cycle suppresses the abort via 'stalled'.
                abort   = (TIMEOUT != 0) && stalled && (cnt == TW'(TIMEOUT));

                swb_cyc_o = cyc_g;
                swb_stb_o = stb_g & ~abort;
                swb_we_o  = g ? m_we_i[1]         : m_we_i[0];
                swb_sel_o = g ? m_sel_i[SW +: SW] : m_sel_i[0 +: SW];
                swb_adr_o = g ? m_adr_i[AW +: AW] : m_adr_i[0 +: AW];
                swb_dat_o = g ? m_dat_i[DW +: DW] : m_dat_i[0 +: DW];
                m_ack_o   = g ? {swb_ack_i, 1'b0} : {1'b0, swb_ack_i};
                m_err_o   = g ? {swb_err_i | abort, 1'b0} : {1'b0, swb_err_i | abort};
                timeout_o = abort;

                if (!cyc_g) begin
                    state_nxt  = IDLE;
                    gnt_nxt    = 2'b00;
                    last_d_nxt = g;
                    cnt_nxt    = '0;
                end else if (swb_ack_i || swb_err_i || abort) begin
                    cnt_nxt = '0;
                end else if (stalled && (TIMEOUT != 0)) begin
                    cnt_nxt = cnt + TW'(1);
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = 2'b00;
            end
        endcase
    end
endmodule

// File: doc/or1200_wb_arbiter.md
Name: or1200_wb_arbiter

Overview:
Two-master to one-slave Wishbone arbiter. It shares a single external memory bus between the or1200_top instruction port (IWB) and data port (DWB). It grants the bus per Wishbone cycle, routes requests and responses, and aborts slave cycles that hang using a watchdog. It sits between or1200_top and the system memory/peripheral interconnect.

Parameters:
AW, 32, address width
DW, 32, data width
PRIORITY_D, 0, 0 = round-robin on ties; 1 = DWB always wins ties
TIMEOUT, 16, max cycles with swb_stb_o high and no ack/err before abort; 0 disables the watchdog
TW, 5, watchdog counter width; must satisfy 2^TW > TIMEOUT

Ports:
clk_i  in  1  system clock; all state on rising edge
rst_i  in  1  synchronous, active-high reset
m_cyc_i  in  2  per-master cycle; bit0 = IWB, bit1 = DWB
m_stb_i  in  2  per-master strobe
m_we_i  in  2  per-master write enable
m_sel_i  in  2*DW/8  byte selects; master k at [k*DW/8 +: DW/8]
m_adr_i  in  2*AW  addresses; master k at [k*AW +: AW]
m_dat_i  in  2*DW  write data; master k at [k*DW +: DW]
m_dat_o  out  DW  read data, broadcast to both masters; valid only with own ack
m_ack_o  out  2  per-master ack
m_err_o  out  2  per-master error (slave err or watchdog abort)
swb_cyc_o  out  1  slave cycle
swb_stb_o  out  1  slave strobe
swb_we_o  out  1  slave write enable
swb_sel_o  out  DW/8  slave byte selects
swb_adr_o  out  AW  slave address
swb_dat_o  out  DW  slave write data
swb_dat_i  in  DW  slave read data
swb_ack_i  in  1  slave ack
swb_err_i  in  1  slave error
gnt_o  out  2  one-hot current owner; 00 = idle
timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- States: IDLE, OWN_I, OWN_D. Registered gnt_o, last-owner flag, watchdog counter.
- Reset (rst_i high at an edge): state IDLE, gnt_o = 00, counter 0, last owner = IWB. Effective at that edge, including mid-transfer.
- All outputs 0 when reset or in IDLE, except m_dat_o = swb_dat_i, which is always passed through.
- Request: req[k] = m_cyc_i[k] & m_stb_i[k].
- In IDLE, arbitration is evaluated each cycle. The winner is registered, so a grant appears the cycle after the request (1-cycle latency).
  - One requester: it wins.
  - Both requesting with PRIORITY_D = 1: DWB wins.
  - Both requesting with PRIORITY_D = 0: the master that was not last owner wins, so DWB wins the first tie after reset.
- While in OWN_x (granted master g):
  - swb_cyc_o = m_cyc_i[g] and swb_stb_o = m_stb_i[g] & ~abort (combinational).
  - swb_we_o, swb_sel_o, swb_adr_o and swb_dat_o are muxed from master g.
  - m_ack_o[g] = swb_ack_i and m_err_o[g] = swb_err_i | abort; the non-granted master's ack/err are 0.
- Release: in OWN_x, if m_cyc_i[g] = 0, then swb_cyc_o is 0 that cycle, last owner is set to g, and the next state is IDLE. Switching owners therefore costs at least one IDLE cycle. Back-to-back cycles by the same master are held without release as long as cyc stays high.
- Ownership is locked for the whole cyc assertion, including multi-beat transfers; the other master is never granted mid-cycle.
- Watchdog:
  - The counter increments each cycle where swb_stb_o = 1 and swb_ack_i = swb_err_i = 0.
  - It clears on ack, on err, on a new grant, and in IDLE.
  - When the counter reaches TIMEOUT-1 while still stalled, abort = 1 on the next stalled cycle. That gives TIMEOUT stalled cycles, then the abort cycle.
  - In the abort cycle: swb_stb_o is forced 0, m_err_o[g] = 1, timeout_o = 1, and the counter clears.
  - The master must then drop cyc or retry.
- A slave ack/err in the same cycle the abort would fire has priority: the response is forwarded and there is no abort.
- Simultaneous swb_ack_i and swb_err_i (illegal for the slave): both are forwarded unchanged.
- A master dropping cyc while a stalled strobe is pending releases the bus immediately; any late slave ack is dropped (IDLE forwards nothing).

Test Plan:
1. IWB read: m_cyc_i = m_stb_i = 01, adr0 = 0x100 at cycle 0; slave acks at cycle 3 with 0xDEADBEEF -> gnt_o = 01 from cycle 1, swb_adr_o = 0x100, m_ack_o = 01 at cycle 3, m_dat_o = 0xDEADBEEF.
2. Tie after reset, PRIORITY_D = 0: both request at cycle 0 -> gnt_o = 10 at cycle 1; after DWB drops cyc -> IDLE for one cycle, then gnt_o = 01; the next tie -> gnt_o = 10.
3. PRIORITY_D = 1: IWB owns the bus, DWB requests mid-cycle -> DWB waits while IWB holds cyc; on release, IDLE then gnt_o = 10, even if IWB re-requests.
4. TIMEOUT = 16, slave never responds -> exactly 16 stalled cycles, then abort cycle: swb_stb_o = 0, m_err_o[g] = 1, timeout_o = 1 for one cycle.
5. TIMEOUT = 16, slave acks on the would-be abort cycle -> m_ack_o[g] = 1, m_err_o = 00, timeout_o = 0.
6. rst_i pulsed during a DWB write with stb high -> at the next edge gnt_o = 00 and all swb_* and m_* outputs are 0 (m_dat_o excepted); the first tie after reset is won by DWB.
